rc4_prga_engine: RTL and testbench



---
 rtl/rc4_prga_engine.sv | 160 ++++++++++++++++
 tb/tb_rc4_prga_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_engine.sv
// rc4_prga_engine: RC4 PRGA keystream/decrypt engine driving S-RAM, E-ROM and D-RAM.
// Define PRGA_CHAR_CHECK_EN to abort a run on a byte outside 'a'..'z' / space.
module rc4_prga_engine #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 6,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] s_q,
    input  logic [DATA_W-1:0] e_q,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren,
    output logic [MSG_AW-1:0] e_addr,
    output logic [MSG_AW-1:0] d_addr,
    output logic [DATA_W-1:0] d_data,
    output logic              d_wren,
    output logic              busy,
    output logic              finish,
    output logic              fail,
    output logic [MSG_AW-1:0] k_cnt
);
    localparam int LW = $clog2(RAM_LAT + 1);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_I, CAP_I, RD_J, WR_I, WR_J, RD_F, CAP_F, WR_D, NEXT, DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] i_q, j_q;
    logic [DATA_W-1:0] si_q, sj_q;
    logic [LW-1:0]     wait_q;
    logic              bad_q;
    logic              lat_done;
    logic [DATA_W-1:0] f_byte;
    logic              char_bad;

    assign lat_done = wait_q == LW'(RAM_LAT);
    assign f_byte   = s_q ^ e_q;

`ifdef PRGA_CHAR_CHECK_EN
    assign char_bad = !((f_byte >= DATA_W'(8'h61) && f_byte <= DATA_W'(8'h7A)) || f_byte == DATA_W'(8'h20));
`else
    assign char_bad = 1'b0;
`endif

    // Outputs are registered: each state sets up what the following state presents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wait_q  <= '0;
            bad_q   <= 1'b0;
            s_addr  <= '0;
            s_data  <= '0;
            s_wren  <= 1'b0;
            e_addr  <= '0;
            d_addr  <= '0;
            d_data  <= '0;
            d_wren  <= 1'b0;
            busy    <= 1'b0;
            finish  <= 1'b0;
            fail    <= 1'b0;
            k_cnt   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_q   <= '0;
                    j_q   <= '0;
                    k_cnt <= '0;
                    fail  <= 1'b0;
                    bad_q <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        state_q <= INC_I;
                    end
                end
                INC_I: begin
                    i_q     <= i_q + 1'b1;
                    s_addr  <= i_q + 1'b1;
                    wait_q  <= '0;
                    state_q <= RD_I;
                end
                RD_I: begin
                    wait_q  <= wait_q + 1'b1;
                    state_q <= lat_done ? CAP_I : RD_I;
                end
                CAP_I: begin
                    si_q    <= s_q;
                    j_q     <= j_q + s_q;
                    s_addr  <= j_q + s_q;
                    wait_q  <= '0;
                    state_q <= RD_J;
                end
                RD_J: begin
                    wait_q <= wait_q + 1'b1;
                    if (lat_done) begin
                        sj_q    <= s_q;
                        s_addr  <= i_q;
                        s_data  <= s_q;
                        s_wren  <= 1'b1;
                        state_q <= WR_I;
                    end
                end
                WR_I: begin
                    s_addr  <= j_q;
                    s_data  <= si_q;
                    state_q <= WR_J;
                end
                WR_J: begin
                    s_wren  <= 1'b0;
                    s_addr  <= si_q + sj_q;
                    e_addr  <= k_cnt;
                    wait_q  <= '0;
                    state_q <= RD_F;
                end
                RD_F: begin
                    wait_q  <= wait_q + 1'b1;
                    state_q <= lat_done ? CAP_F : RD_F;
                end
                CAP_F: begin
                    d_data  <= f_byte;
                    d_addr  <= k_cnt;
                    d_wren  <= 1'b1;
                    bad_q   <= char_bad;
                    state_q <= WR_D;
                end
                WR_D: begin
                    d_wren  <= 1'b0;
                    k_cnt   <= k_cnt + 1'b1;
                    state_q <= NEXT;
                end
                NEXT: begin
                    if (k_cnt == MSG_AW'(MSG_LEN) || bad_q) begin
                        busy    <= 1'b0;
                        finish  <= 1'b1;
                        fail    <= bad_q;
                        state_q <= DONE;
                    end else begin
                        state_q <= INC_I;
                    end
                end
                DONE: begin
                    if (!start) begin
                        finish  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_prga_engine.sv
// tb_rc4_prga_engine: directed checks of the RC4 PRGA engine with identity S-box and behavioural memories.
// dut0 uses default parameters; dut1 uses RAM_LAT=1, MSG_LEN=4.
module tb_rc4_prga_engine;
    logic clk = 1'b0, reset_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, init0 = 1'b0, init1 = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] s_q0, e_q0, s_addr0, s_data0, d_data0;
    logic [5:0] e_addr0, d_addr0, k_cnt0;
    logic       s_wren0, d_wren0, busy0, finish0, fail0;
    logic [7:0] s_q1, e_q1, s_addr1, s_data1, d_data1;
    logic [5:0] e_addr1, d_addr1, k_cnt1;
    logic       s_wren1, d_wren1, busy1, finish1, fail1;

    rc4_prga_engine dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .s_q(s_q0), .e_q(e_q0),
        .s_addr(s_addr0), .s_data(s_data0), .s_wren(s_wren0), .e_addr(e_addr0),
        .d_addr(d_addr0), .d_data(d_data0), .d_wren(d_wren0), .busy(busy0),
        .finish(finish0), .fail(fail0), .k_cnt(k_cnt0)
    );

    rc4_prga_engine #(.MSG_LEN(4), .RAM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .s_q(s_q1), .e_q(e_q1),
        .s_addr(s_addr1), .s_data(s_data1), .s_wren(s_wren1), .e_addr(e_addr1),
        .d_addr(d_addr1), .d_data(d_data1), .d_wren(d_wren1), .busy(busy1),
        .finish(finish1), .fail(fail1), .k_cnt(k_cnt1)
    );

    logic [7:0] s0 [256], e0 [64], d0 [64], s1 [256], e1 [64], d1 [64];
    logic [7:0] sp0a, sp0b, ep0a, ep0b, sp1, ep1;
    int sw0 = 0, dw0 = 0, sw1 = 0, dw1 = 0;

    always @(posedge clk) begin
        sp0a <= s0[s_addr0];
        sp0b <= sp0a;
        ep0a <= e0[e_addr0];
        ep0b <= ep0a;
        if (init0) begin
            for (int n = 0; n < 256; n++) s0[n] <= 8'(n);
            for (int n = 0; n < 64; n++) d0[n] <= 8'h00;
        end else begin
            if (s_wren0) begin
                s0[s_addr0] <= s_data0;
                sw0 <= sw0 + 1;
            end
            if (d_wren0) begin
                d0[d_addr0] <= d_data0;
                dw0 <= dw0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        sp1 <= s1[s_addr1];
        ep1 <= e1[e_addr1];
        if (init1) begin
            for (int n = 0; n < 256; n++) s1[n] <= 8'(n);
            for (int n = 0; n < 64; n++) d1[n] <= 8'h00;
        end else begin
            if (s_wren1) begin
                s1[s_addr1] <= s_data1;
                sw1 <= sw1 + 1;
            end
            if (d_wren1) begin
                d1[d_addr1] <= d_data1;
                dw1 <= dw1 + 1;
            end
        end
    end

    assign s_q0 = sp0b;
    assign e_q0 = ep0b;
    assign s_q1 = sp1;
    assign e_q1 = ep1;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs0();
        return {s_addr0, s_data0, s_wren0, e_addr0, d_addr0, d_data0, d_wren0, busy0, finish0, fail0, k_cnt0};
    endfunction

    function automatic logic [63:0] outs1();
        return {s_addr1, s_data1, s_wren1, e_addr1, d_addr1, d_data1, d_wren1, busy1, finish1, fail1, k_cnt1};
    endfunction

    task automatic load0();
        @(negedge clk) init0 = 1'b1;
        @(negedge clk) init0 = 1'b0;
    endtask

    task automatic idle0();
        @(negedge clk) start0 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] snap_s2, snap_s3;
    logic       snap_fail;

    // Counts edges after the start-sampling edge until finish; snapshots state once k_cnt reaches 2.
    task automatic run0(output int n);
        bit seen;
        seen = 1'b0;
        snap_s2 = 8'hEE;
        snap_s3 = 8'hEE;
        snap_fail = 1'bx;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!seen && k_cnt0 == 6'd2) begin
                seen = 1'b1;
                snap_s2 = s0[2];
                snap_s3 = s0[3];
                snap_fail = fail0;
            end
        end while (!finish0 && n < 5000);
    endtask

`ifdef PRGA_CHAR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    initial begin
        int n, w0, w1;
        for (int a = 0; a < 64; a++) begin
            e0[a] = 8'h00;
            e1[a] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs0", outs0(), 64'd0);
        check("reset_outs1", outs1(), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        load0();
        @(negedge clk) init1 = 1'b1;
        @(negedge clk) init1 = 1'b0;

        // T1 / T3: E all zero
        run0(n);
        check("t1_cycles", 64'(n), CHK ? 64'd16 : 64'd512);
        check("t1_kcnt", 64'(k_cnt0), CHK ? 64'd1 : 64'd32);
        check("t1_fail", 64'(fail0), 64'(CHK));
        check("t1_busy", 64'(busy0), 64'd0);
        check("t1_d0", 64'(d0[0]), 64'h02);
`ifndef PRGA_CHAR_CHECK_EN
        check("t1_d1", 64'(d0[1]), 64'h05);
        check("t1_d2", 64'(d0[2]), 64'h07);
        check("t1_s2_byte1", 64'(snap_s2), 64'h03);
        check("t1_s3_byte1", 64'(snap_s3), 64'h02);
`endif

        // T5: start held high in DONE must not launch another run
        w0 = dw0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_finish_held", 64'(finish0), 64'd1);
        check("t5_busy_held", 64'(busy0), 64'd0);
        check("t5_no_writes", 64'(dw0), 64'(w0));
        idle0();
        check("t5_idle_finish", 64'(finish0), 64'd0);

        // T2: plaintext bytes 'a','a'
        e0[0] = 8'h63;
        e0[1] = 8'h64;
        load0();
        run0(n);
        check("t2_d0", 64'(d0[0]), 64'h61);
        check("t2_d1", 64'(d0[1]), 64'h61);
        check("t2_fail_byte1", 64'(snap_fail), 64'd0);
        check("t2_kcnt", 64'(k_cnt0), CHK ? 64'd3 : 64'd32);
        check("t2_fail", 64'(fail0), 64'(CHK));
        check("t2_d2", 64'(d0[2]), 64'h07);
        idle0();
        e0[0] = 8'h00;
        e0[1] = 8'h00;

        // T4: asynchronous reset at cycle 40, then restart
        load0();
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        repeat (40) @(posedge clk);
        #2;
        check("t4_active", {busy0, finish0}, CHK ? 64'd1 : 64'd2);
        reset_n = 1'b0;
        #1;
        check("t4_reset_outs", outs0(), 64'd0);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load0();
        run0(n);
        check("t4_d0", 64'(d0[0]), 64'h02);
        check("t4_cycles", 64'(n), CHK ? 64'd16 : 64'd512);
        idle0();

        // T6: RAM_LAT=1, MSG_LEN=4
        w0 = sw1;
        w1 = dw1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!finish1 && n < 2000);
        check("t6_cycles", 64'(n), CHK ? 64'd13 : 64'd52);
        check("t6_s_wren", 64'(sw1 - w0), CHK ? 64'd2 : 64'd8);
        check("t6_d_wren", 64'(dw1 - w1), CHK ? 64'd1 : 64'd4);
        check("t6_kcnt", 64'(k_cnt1), CHK ? 64'd1 : 64'd4);
        check("t6_d0", 64'(d1[0]), 64'h02);
`ifndef PRGA_CHAR_CHECK_EN
        check("t6_d3", 64'(d1[3]), 64'h0D);
`endif
        @(negedge clk) start1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
